// File: rtl/mci_pkg.sv
// Shared types for the MCI production debug-unlock arbiter: FSM states,
// response status encoding and the level-index width.
package mci_pkg;

  localparam int unsigned MCI_DBG_LVL_IDX_W = 6;

  typedef enum logic [2:0] {
    MCI_DBG_IDLE      = 3'd0,
    MCI_DBG_CHECK     = 3'd1,
    MCI_DBG_WAIT_CORE = 3'd2,
    MCI_DBG_RESP      = 3'd3,
    MCI_DBG_LOCKOUT   = 3'd4
  } mci_dbg_unlock_fsm_e;

  typedef enum logic [2:0] {
    MCI_DBG_RSP_PASS    = 3'd0,
    MCI_DBG_RSP_FAIL    = 3'd1,
    MCI_DBG_RSP_TIMEOUT = 3'd2,
    MCI_DBG_RSP_REJECT  = 3'd3,
    MCI_DBG_RSP_LOCKOUT = 3'd4,
    MCI_DBG_RSP_ABORT   = 3'd5
  } mci_dbg_unlock_status_e;

endpackage

// File: rtl/mci_rr_arb.sv
// Combinational round-robin picker: first set request at or after the pointer,
// as a one-hot grant plus its index.
module mci_rr_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      gnt_idx_o,
  output logic               gnt_vld_o
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((32'(ptr_i) + 32'(i)) % NUM_REQ);
      if (!gnt_vld_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        gnt_vld_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mci_dbg_unlock_arb.sv
// Production debug-unlock arbiter: round-robin selects one requester, runs the
// Caliptra core level check and latches the granted one-hot unlock level.
module mci_dbg_unlock_arb
  import mci_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned LVL_W       = 64,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned MAX_FAIL    = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   prod_unlock_allow_i,
  input  logic                                   clear_i,
  input  logic [NUM_REQ-1:0]                     req_valid_i,
  input  logic [NUM_REQ*MCI_DBG_LVL_IDX_W-1:0]   req_level_i,
  output logic [NUM_REQ-1:0]                     req_ack_o,
  output logic [NUM_REQ-1:0]                     rsp_valid_o,
  output logic [2:0]                             rsp_status_o,
  output logic                                   core_req_o,
  output logic [MCI_DBG_LVL_IDX_W-1:0]           core_level_o,
  input  logic                                   core_done_i,
  input  logic                                   core_pass_i,
  output logic [LVL_W-1:0]                       ss_soc_dbg_unlock_level_o,
  output logic                                   busy_o,
  output mci_dbg_unlock_fsm_e                    dbg_state_o
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned FW = (MAX_FAIL > 0) ? $clog2(MAX_FAIL + 1) : 1;
  localparam int unsigned IW = MCI_DBG_LVL_IDX_W;

  localparam logic [TW-1:0]      TMR_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [FW-1:0]      FAIL_SAT = FW'(MAX_FAIL);
  localparam logic [PW-1:0]      PTR_LAST = PW'(NUM_REQ - 1);
  localparam logic [LVL_W-1:0]   LVL_ONE  = LVL_W'(1);
  localparam logic [NUM_REQ-1:0] REQ_ONE  = NUM_REQ'(1);

  // Handshakes: a requester holds req_valid_i (and its level) until it sees
  // its req_ack_o pulse; the single rsp_valid_o pulse later carries
  // rsp_status_o. Toward the core, core_req_o/core_level_o stay put until the
  // one-cycle core_done_i, whose core_pass_i is sampled in that same cycle.

  mci_dbg_unlock_fsm_e    state_q;
  mci_dbg_unlock_status_e rsp_status_q;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]          owner_q;
  logic [IW-1:0]          lvl_idx_q;
  logic [TW-1:0]          timer_q, timer_d;
  logic [FW-1:0]          fail_cnt_q, fail_cnt_d;
  logic [NUM_REQ-1:0]     req_ack_q;
  logic [NUM_REQ-1:0]     rsp_valid_q;
  logic                   core_req_q;
  logic [LVL_W-1:0]       level_q;

  logic [NUM_REQ-1:0]     gnt;
  logic [PW-1:0]          gnt_idx;
  logic                   gnt_vld;
  logic [IW-1:0]          sel_lvl;
  logic                   lvl_bad;
  logic [NUM_REQ-1:0]     owner_oh;
  logic [LVL_W-1:0]       level_set;

  mci_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_arb (
    .req_i     (req_valid_i),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    sel_lvl = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PW'(i)) sel_lvl = req_level_i[i*IW +: IW];
    end
  end

  // The 6-bit index can exceed a narrower LVL_W build, so the range check stays.
  assign lvl_bad    = (32'(lvl_idx_q) >= LVL_W);
  assign owner_oh   = REQ_ONE << owner_q;
  assign level_set  = LVL_ONE << lvl_idx_q;
  assign rr_ptr_d   = (owner_q == PTR_LAST) ? '0 : owner_q + PW'(1);
  assign timer_d    = (timer_q == TMR_LAST) ? timer_q : timer_q + TW'(1);
  assign fail_cnt_d = (fail_cnt_q >= FAIL_SAT) ? FAIL_SAT : fail_cnt_q + FW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MCI_DBG_IDLE;
      rsp_status_q <= MCI_DBG_RSP_PASS;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      lvl_idx_q    <= '0;
      timer_q      <= '0;
      fail_cnt_q   <= '0;
      req_ack_q    <= '0;
      rsp_valid_q  <= '0;
      core_req_q   <= 1'b0;
      level_q      <= '0;
    end else begin
      req_ack_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_status_q <= MCI_DBG_RSP_PASS;
      if (clear_i) level_q <= '0;

      unique case (state_q)
        MCI_DBG_IDLE, MCI_DBG_LOCKOUT: begin
          // Lockout still accepts requests so every requester gets an answer.
          if (gnt_vld) begin
            owner_q   <= gnt_idx;
            lvl_idx_q <= sel_lvl;
            req_ack_q <= gnt;
            state_q   <= MCI_DBG_CHECK;
          end
        end

        MCI_DBG_CHECK: begin
          if (lvl_bad || !prod_unlock_allow_i) begin
            rsp_valid_q  <= owner_oh;
            rsp_status_q <= MCI_DBG_RSP_REJECT;
            state_q      <= MCI_DBG_RESP;
          end else if (fail_cnt_q >= FAIL_SAT) begin
            rsp_valid_q  <= owner_oh;
            rsp_status_q <= MCI_DBG_RSP_LOCKOUT;
            state_q      <= MCI_DBG_RESP;
          end else begin
            core_req_q <= 1'b1;
            timer_q    <= '0;
            state_q    <= MCI_DBG_WAIT_CORE;
          end
        end

        MCI_DBG_WAIT_CORE: begin
          if (clear_i) begin
            core_req_q   <= 1'b0;
            rsp_valid_q  <= owner_oh;
            rsp_status_q <= MCI_DBG_RSP_ABORT;
            state_q      <= MCI_DBG_RESP;
          end else if (core_done_i) begin
            core_req_q  <= 1'b0;
            rsp_valid_q <= owner_oh;
            state_q     <= MCI_DBG_RESP;
            if (core_pass_i) begin
              level_q      <= level_set;
              rsp_status_q <= MCI_DBG_RSP_PASS;
            end else begin
              fail_cnt_q   <= fail_cnt_d;
              rsp_status_q <= MCI_DBG_RSP_FAIL;
            end
          end else if (timer_q == TMR_LAST) begin
            core_req_q   <= 1'b0;
            fail_cnt_q   <= fail_cnt_d;
            rsp_valid_q  <= owner_oh;
            rsp_status_q <= MCI_DBG_RSP_TIMEOUT;
            state_q      <= MCI_DBG_RESP;
          end else begin
            timer_q <= timer_d;
          end
        end

        MCI_DBG_RESP: begin
          rr_ptr_q <= rr_ptr_d;
          if (fail_cnt_q == FAIL_SAT) begin
            level_q <= '0;
            state_q <= MCI_DBG_LOCKOUT;
          end else begin
            state_q <= MCI_DBG_IDLE;
          end
        end

        default: state_q <= MCI_DBG_IDLE;
      endcase
    end
  end

  assign req_ack_o                 = req_ack_q;
  assign rsp_valid_o               = rsp_valid_q;
  assign rsp_status_o              = rsp_status_q;
  assign core_req_o                = core_req_q;
  assign core_level_o              = lvl_idx_q;
  assign ss_soc_dbg_unlock_level_o = level_q;
  assign busy_o                    = (state_q != MCI_DBG_IDLE) && (state_q != MCI_DBG_LOCKOUT);
  assign dbg_state_o               = state_q;

  a_level_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(level_q));
  a_ack_onehot0:   assert property (@(posedge clk) disable iff (rst) $onehot0(req_ack_q));
  a_rsp_onehot0:   assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid_q));
  a_core_lvl_stable: assert property (@(posedge clk) disable iff (rst)
    (core_req_q && $past(core_req_q)) |-> $stable(lvl_idx_q));

endmodule

// File: tb/tb_mci_dbg_unlock_arb.sv
// Directed bench for mci_dbg_unlock_arb: latency, round-robin order, timeout
// lockout, reject, clear/abort and async reset, with hand-computed expectations.
module tb_mci_dbg_unlock_arb;
  import mci_pkg::*;

  localparam int NUM_REQ     = 2;
  localparam int LVL_W       = 64;
  localparam int TIMEOUT_CYC = 4096;
  localparam int MAX_FAIL    = 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    prod_unlock_allow_i = 1'b1;
  logic                    clear_i = 1'b0;
  logic [NUM_REQ-1:0]      req_valid_i = '0;
  logic [NUM_REQ*6-1:0]    req_level_i = '0;
  logic [NUM_REQ-1:0]      req_ack_o;
  logic [NUM_REQ-1:0]      rsp_valid_o;
  logic [2:0]              rsp_status_o;
  logic                    core_req_o;
  logic [5:0]              core_level_o;
  logic                    core_done_i = 1'b0;
  logic                    core_pass_i = 1'b0;
  logic [LVL_W-1:0]        ss_soc_dbg_unlock_level_o;
  logic                    busy_o;
  mci_dbg_unlock_fsm_e     dbg_state_o;

  mci_dbg_unlock_arb #(
    .NUM_REQ     (NUM_REQ),
    .LVL_W       (LVL_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MAX_FAIL    (MAX_FAIL)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .prod_unlock_allow_i       (prod_unlock_allow_i),
    .clear_i                   (clear_i),
    .req_valid_i               (req_valid_i),
    .req_level_i               (req_level_i),
    .req_ack_o                 (req_ack_o),
    .rsp_valid_o               (rsp_valid_o),
    .rsp_status_o              (rsp_status_o),
    .core_req_o                (core_req_o),
    .core_level_o              (core_level_o),
    .core_done_i               (core_done_i),
    .core_pass_i               (core_pass_i),
    .ss_soc_dbg_unlock_level_o (ss_soc_dbg_unlock_level_o),
    .busy_o                    (busy_o),
    .dbg_state_o               (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [NUM_REQ+2:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst                 = 1'b1;
    req_valid_i         = '0;
    req_level_i         = '0;
    clear_i             = 1'b0;
    core_done_i         = 1'b0;
    core_pass_i         = 1'b0;
    prod_unlock_allow_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // driver tasks
  task automatic raise(input int r, input logic [5:0] lvl);
    req_valid_i[r]       = 1'b1;
    req_level_i[r*6 +: 6] = lvl;
  endtask

  task automatic expect_rsp(input int r, input mci_dbg_unlock_status_e st);
    exp_q.push_back({NUM_REQ'(32'd1 << r), 3'(st)});
  endtask

  task automatic check_rsp(input string tag);
    logic [NUM_REQ+2:0] exp;
    exp = '1;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    check({tag, "_rsp"}, 64'({rsp_valid_o, rsp_status_o}), 64'(exp));
  endtask

  task automatic wait_ack(input string tag, input int r);
    int n = 0;
    while (req_ack_o == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ack"}, 64'(req_ack_o), 64'd1 << r);
    req_valid_i[r] = 1'b0;
  endtask

  task automatic wait_core(input string tag, input logic [5:0] lvl);
    int n = 0;
    while (!core_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_core_req"}, 64'(core_req_o), 64'd1);
    check({tag, "_core_lvl"}, 64'(core_level_o), 64'(lvl));
  endtask

  task automatic pulse_done(input logic pass, input logic clr);
    core_done_i = 1'b1;
    core_pass_i = pass;
    clear_i     = clr;
    @(negedge clk);
    core_done_i = 1'b0;
    core_pass_i = 1'b0;
    clear_i     = 1'b0;
  endtask

  task automatic serve(input string tag, input int r, input logic [5:0] lvl, input logic pass,
                       input mci_dbg_unlock_status_e st, input logic [63:0] exp_level);
    raise(r, lvl);
    expect_rsp(r, st);
    wait_ack(tag, r);
    wait_core(tag, lvl);
    pulse_done(pass, 1'b0);
    check_rsp(tag);
    check({tag, "_level"}, ss_soc_dbg_unlock_level_o, exp_level);
    @(negedge clk);
  endtask

  task automatic serve_nocore(input string tag, input int r, input logic [5:0] lvl,
                              input mci_dbg_unlock_status_e st);
    raise(r, lvl);
    expect_rsp(r, st);
    wait_ack(tag, r);
    @(negedge clk);
    check({tag, "_no_core"}, 64'(core_req_o), 64'd0);
    check_rsp(tag);
    @(negedge clk);
  endtask

  initial begin
    int n;

    // reset state
    do_reset();
    check("rst_ack", 64'(req_ack_o), 64'd0);
    check("rst_rsp", 64'(rsp_valid_o), 64'd0);
    check("rst_core_req", 64'(core_req_o), 64'd0);
    check("rst_level", ss_soc_dbg_unlock_level_o, 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_state", 64'(dbg_state_o), 64'(MCI_DBG_IDLE));

    // basic pass with exact latency
    raise(0, 6'd5);
    expect_rsp(0, MCI_DBG_RSP_PASS);
    @(negedge clk);
    check("t1_ack", 64'(req_ack_o), 64'd1);
    check("t1_core_early", 64'(core_req_o), 64'd0);
    req_valid_i[0] = 1'b0;
    @(negedge clk);
    check("t1_core_req", 64'(core_req_o), 64'd1);
    check("t1_core_lvl", 64'(core_level_o), 64'd5);
    check("t1_busy", 64'(busy_o), 64'd1);
    repeat (10) @(negedge clk);
    check("t1_core_hold", 64'(core_req_o), 64'd1);
    pulse_done(1'b1, 1'b0);
    check_rsp("t1");
    check("t1_level", ss_soc_dbg_unlock_level_o, 64'h20);
    check("t1_core_drop", 64'(core_req_o), 64'd0);
    @(negedge clk);
    check("t1_busy_after", 64'(busy_o), 64'd0);
    check("t1_rsp_pulse", 64'(rsp_valid_o), 64'd0);
    check("t1_level_hold", ss_soc_dbg_unlock_level_o, 64'h20);
    pulse_done(1'b1, 1'b0);
    check("stray_done_rsp", 64'(rsp_valid_o), 64'd0);
    check("stray_done_state", 64'(dbg_state_o), 64'(MCI_DBG_IDLE));

    // round robin
    do_reset();
    raise(0, 6'd1);
    raise(1, 6'd2);
    expect_rsp(0, MCI_DBG_RSP_PASS);
    expect_rsp(1, MCI_DBG_RSP_PASS);
    expect_rsp(0, MCI_DBG_RSP_PASS);
    wait_ack("rr_a", 0);
    wait_core("rr_a", 6'd1);
    pulse_done(1'b1, 1'b0);
    check_rsp("rr_a");
    check("rr_a_level", ss_soc_dbg_unlock_level_o, 64'h2);
    raise(0, 6'd1);
    wait_ack("rr_b", 1);
    wait_core("rr_b", 6'd2);
    pulse_done(1'b1, 1'b0);
    check_rsp("rr_b");
    check("rr_b_level", ss_soc_dbg_unlock_level_o, 64'h4);
    wait_ack("rr_c", 0);
    wait_core("rr_c", 6'd1);
    pulse_done(1'b1, 1'b0);
    check_rsp("rr_c");
    check("rr_c_level", ss_soc_dbg_unlock_level_o, 64'h2);
    @(negedge clk);

    // reject leaves the failure count alone
    do_reset();
    serve("f1", 0, 6'd4, 1'b0, MCI_DBG_RSP_FAIL, 64'd0);
    serve("f2", 1, 6'd4, 1'b0, MCI_DBG_RSP_FAIL, 64'd0);
    prod_unlock_allow_i = 1'b0;
    serve_nocore("rej1", 0, 6'd4, MCI_DBG_RSP_REJECT);
    serve_nocore("rej2", 1, 6'd63, MCI_DBG_RSP_REJECT);
    check("rej_state", 64'(dbg_state_o), 64'(MCI_DBG_IDLE));
    prod_unlock_allow_i = 1'b1;
    serve("after_rej", 0, 6'd63, 1'b1, MCI_DBG_RSP_PASS, 64'h8000_0000_0000_0000);
    check("after_rej_state", 64'(dbg_state_o), 64'(MCI_DBG_IDLE));

    // clear and abort
    do_reset();
    serve("lv3", 0, 6'd3, 1'b1, MCI_DBG_RSP_PASS, 64'h8);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    check("clr_level", ss_soc_dbg_unlock_level_o, 64'd0);
    serve("lv3b", 1, 6'd3, 1'b1, MCI_DBG_RSP_PASS, 64'h8);
    raise(0, 6'd6);
    expect_rsp(0, MCI_DBG_RSP_ABORT);
    wait_ack("abort", 0);
    wait_core("abort", 6'd6);
    pulse_done(1'b1, 1'b1);
    check_rsp("abort");
    check("abort_level", ss_soc_dbg_unlock_level_o, 64'd0);
    check("abort_core", 64'(core_req_o), 64'd0);
    @(negedge clk);
    check("abort_busy", 64'(busy_o), 64'd0);

    // async reset during WAIT_CORE
    serve("pre", 0, 6'd10, 1'b1, MCI_DBG_RSP_PASS, 64'h400);
    serve("pre_f1", 1, 6'd1, 1'b0, MCI_DBG_RSP_FAIL, 64'h400);
    serve("pre_f2", 0, 6'd1, 1'b0, MCI_DBG_RSP_FAIL, 64'h400);
    raise(1, 6'd7);
    wait_ack("mid", 1);
    wait_core("mid", 6'd7);
    #2 rst = 1'b1;
    #1;
    check("arst_core", 64'(core_req_o), 64'd0);
    check("arst_level", ss_soc_dbg_unlock_level_o, 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_rsp", 64'({req_ack_o, rsp_valid_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    serve("post_f", 0, 6'd2, 1'b0, MCI_DBG_RSP_FAIL, 64'd0);
    check("post_f_state", 64'(dbg_state_o), 64'(MCI_DBG_IDLE));
    serve("post_p", 1, 6'd5, 1'b1, MCI_DBG_RSP_PASS, 64'h20);

    // timeouts to lockout
    do_reset();
    for (int k = 0; k < MAX_FAIL; k++) begin
      raise(0, 6'd7);
      expect_rsp(0, MCI_DBG_RSP_TIMEOUT);
      wait_ack($sformatf("to%0d", k), 0);
      wait_core($sformatf("to%0d", k), 6'd7);
      n = 0;
      while (rsp_valid_o == '0 && n < 5000) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("to%0d_latency", k), 64'(n), 64'(TIMEOUT_CYC));
      check($sformatf("to%0d_core_drop", k), 64'(core_req_o), 64'd0);
      check_rsp($sformatf("to%0d", k));
      @(negedge clk);
    end
    check("lock_state", 64'(dbg_state_o), 64'(MCI_DBG_LOCKOUT));
    check("lock_busy", 64'(busy_o), 64'd0);
    serve_nocore("lock1", 1, 6'd5, MCI_DBG_RSP_LOCKOUT);
    check("lock1_level", ss_soc_dbg_unlock_level_o, 64'd0);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    serve_nocore("lock2", 0, 6'd5, MCI_DBG_RSP_LOCKOUT);
    check("lock2_state", 64'(dbg_state_o), 64'(MCI_DBG_LOCKOUT));
    check("lock2_level", ss_soc_dbg_unlock_level_o, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
